// File: rtl/spiking_lif_pe.sv
// Leaky integrate-and-fire processing element for a systolic spiking array.
// Integrates weighted row spikes, leaks/fires on step_end, forwards row/col east/south.
module spiking_lif_pe #(
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int LEAK_SHIFT   = 4,
  parameter int RESET_MODE   = 0,
  parameter int REFRAC_STEPS = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_row,
  input  logic [DATA_WIDTH-1:0] in_col,
  input  logic                  step_end,
  input  logic [ACC_WIDTH-1:0]  threshold,
  output logic                  out_valid,
  output logic                  out_row,
  output logic [DATA_WIDTH-1:0] out_col,
  output logic                  out_spike,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]  spike_cnt
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // One guard bit is enough for a single add/subtract; clamp when it disagrees with the MSB.
  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [ACC_WIDTH:0] x);
    if (x[ACC_WIDTH] != x[ACC_WIDTH-1])
      return x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return x[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [ACC_WIDTH:0] ext(input logic signed [ACC_WIDTH-1:0] a);
    return {a[ACC_WIDTH-1], a};
  endfunction

  logic signed [DATA_WIDTH-1:0] col_s;
  logic signed [ACC_WIDTH-1:0]  v;
  logic signed [ACC_WIDTH-1:0]  c;
  logic signed [ACC_WIDTH-1:0]  s;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [ACC_WIDTH-1:0]  lk;
  logic signed [ACC_WIDTH-1:0]  residue;
  logic signed [ACC_WIDTH-1:0]  thr;
  logic [3:0]                   refrac;
  logic                         fire;

  assign col_s    = in_col;
  assign out_data = v;

  always_comb begin
    thr     = threshold;
    c       = '0;
    if (in_valid && in_row && (refrac == '0))
      c = ACC_WIDTH'(col_s);
    s       = sat(ext(v) + ext(c));
    shifted = s >>> LEAK_SHIFT;
    lk      = (LEAK_SHIFT == 0) ? s : sat(ext(s) - ext(shifted));
    residue = sat(ext(lk) - ext(thr));
    fire    = (lk >= thr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= 1'b0;
      out_col   <= '0;
      out_spike <= 1'b0;
      v         <= '0;
      refrac    <= '0;
      spike_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      out_row   <= in_row;
      out_col   <= in_col;
      out_spike <= 1'b0;
      if (!step_end) begin
        v <= s;
      end else if (refrac != '0) begin
        v      <= '0;
        refrac <= refrac - 4'd1;
      end else if (fire) begin
        out_spike <= 1'b1;
        v         <= (RESET_MODE != 0) ? residue : '0;
        refrac    <= 4'(REFRAC_STEPS);
        if (spike_cnt != '1)
          spike_cnt <= spike_cnt + CNT_WIDTH'(1);
      end else begin
        v <= lk;
      end
    end
  end

endmodule

// File: tb/tb_spiking_lif_pe.sv
// Bench for spiking_lif_pe: directed scenarios on three parameterisations plus a
// randomized run against an unbounded-integer reference model.
module tb_spiking_lif_pe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_row = 1'b0;
  logic [15:0] in_col = '0;
  logic        step_end = 1'b0;
  logic [23:0] threshold = '0;

  // a: defaults, b: subtract-threshold reset, w: 16-bit membrane, no leak, no refractory
  logic               a_valid, a_row, a_spike;
  logic [15:0]        a_col;
  logic signed [23:0] a_data;
  logic [7:0]         a_cnt;
  logic               b_valid, b_row, b_spike;
  logic [15:0]        b_col;
  logic signed [23:0] b_data;
  logic [7:0]         b_cnt;
  logic               w_valid, w_row, w_spike;
  logic [15:0]        w_col;
  logic signed [15:0] w_data;
  logic [7:0]         w_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  spiking_lif_pe dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
    .step_end(step_end), .threshold(threshold),
    .out_valid(a_valid), .out_row(a_row), .out_col(a_col), .out_spike(a_spike),
    .out_data(a_data), .spike_cnt(a_cnt)
  );

  spiking_lif_pe #(.RESET_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
    .step_end(step_end), .threshold(threshold),
    .out_valid(b_valid), .out_row(b_row), .out_col(b_col), .out_spike(b_spike),
    .out_data(b_data), .spike_cnt(b_cnt)
  );

  spiking_lif_pe #(.DATA_WIDTH(16), .ACC_WIDTH(16), .LEAK_SHIFT(0), .REFRAC_STEPS(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
    .step_end(step_end), .threshold(threshold[15:0]),
    .out_valid(w_valid), .out_row(w_row), .out_col(w_col), .out_spike(w_spike),
    .out_data(w_data), .spike_cnt(w_cnt)
  );

  // Reference model state for dut_a (index 0) and dut_w (index 1)
  longint mv[2];
  int     mr[2];
  int     mc[2];
  bit     mf[2];
  int     maw[2] = '{24, 16};
  int     mls[2] = '{4, 0};
  int     mrs[2] = '{2, 0};

  function automatic longint clampv(longint x, int aw);
    longint hi = (longint'(1) <<< (aw - 1)) - 1;
    longint lo = -(longint'(1) <<< (aw - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  task automatic model_tick(int k, bit vld, bit row, longint colv, bit se, longint th);
    longint c, s, lk;
    c = (vld && row && mr[k] == 0) ? colv : 0;
    s = clampv(mv[k] + c, maw[k]);
    mf[k] = 1'b0;
    if (!se) begin
      mv[k] = s;
    end else begin
      lk = (mls[k] == 0) ? s : clampv(s - (s >>> mls[k]), maw[k]);
      if (mr[k] != 0) begin
        mv[k] = 0;
        mr[k] = mr[k] - 1;
      end else if (lk >= th) begin
        mf[k] = 1'b1;
        mv[k] = 0;
        mr[k] = mrs[k];
        if (mc[k] < 255) mc[k] = mc[k] + 1;
      end else begin
        mv[k] = lk;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit vld, bit row, logic [15:0] col, bit se);
    in_valid = vld;
    in_row   = row;
    in_col   = col;
    step_end = se;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 0, 16'h0000, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    threshold = -24'sd5;
    drive(1, 1, 16'h5555, 1);
    tick();
    checks++; if (a_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", a_valid); else passed++;
    checks++; if (a_row !== 1'b0) $display("FAIL reset_row got=%0b exp=0", a_row); else passed++;
    checks++; if (a_col !== 16'h0000) $display("FAIL reset_col got=%h exp=0000", a_col); else passed++;
    checks++; if (a_spike !== 1'b0) $display("FAIL reset_spike got=%0b exp=0", a_spike); else passed++;
    checks++; if (a_data !== 24'sd0) $display("FAIL reset_data got=%0d exp=0", a_data); else passed++;
    checks++; if (a_cnt !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", a_cnt); else passed++;
    rst = 1'b0;
    drive(0, 0, 16'h0000, 0);
  endtask

  task automatic test_fire();
    apply_reset();
    threshold = 24'sd100;
    drive(1, 1, 16'd40, 0); tick();
    checks++; if (a_data !== 24'sd40) $display("FAIL fire_int1 got=%0d exp=40", a_data); else passed++;
    drive(1, 1, 16'd40, 0); tick();
    checks++; if (a_data !== 24'sd80) $display("FAIL fire_int2 got=%0d exp=80", a_data); else passed++;
    checks++; if (b_data !== 24'sd80) $display("FAIL fire_int2_b got=%0d exp=80", b_data); else passed++;
    drive(1, 1, 16'd40, 1); tick();
    checks++; if (a_spike !== 1'b1) $display("FAIL fire_spike got=%0b exp=1", a_spike); else passed++;
    checks++; if (a_data !== 24'sd0) $display("FAIL fire_data got=%0d exp=0", a_data); else passed++;
    checks++; if (a_cnt !== 8'd1) $display("FAIL fire_cnt got=%0d exp=1", a_cnt); else passed++;
    checks++; if (b_spike !== 1'b1) $display("FAIL fire_spike_b got=%0b exp=1", b_spike); else passed++;
    checks++; if (b_data !== 24'sd13) $display("FAIL fire_sub_data got=%0d exp=13", b_data); else passed++;
    checks++; if (w_spike !== 1'b1) $display("FAIL fire_spike_w got=%0b exp=1", w_spike); else passed++;
    checks++; if (w_data !== 16'sd0) $display("FAIL fire_data_w got=%0d exp=0", w_data); else passed++;
    drive(0, 0, 16'h0000, 0); tick();
    checks++; if (a_spike !== 1'b0) $display("FAIL fire_pulse_width got=%0b exp=0", a_spike); else passed++;
    checks++; if (w_spike !== 1'b0) $display("FAIL fire_pulse_width_w got=%0b exp=0", w_spike); else passed++;
  endtask

  // Continues from test_fire: dut_a is refractory for exactly two steps
  task automatic test_refractory();
    for (int st = 0; st < 2; st++) begin
      for (int cy = 0; cy < 3; cy++) begin
        drive(1, 1, 16'd200, (cy == 2));
        tick();
        checks++; if (a_data !== 24'sd0) $display("FAIL refrac_data st=%0d cy=%0d got=%0d exp=0", st, cy, a_data); else passed++;
        checks++; if (a_spike !== 1'b0) $display("FAIL refrac_spike st=%0d cy=%0d got=%0b exp=0", st, cy, a_spike); else passed++;
        checks++; if (a_col !== 16'd200 || a_valid !== 1'b1 || a_row !== 1'b1)
          $display("FAIL refrac_forward st=%0d cy=%0d got=%0d/%0b/%0b exp=200/1/1", st, cy, a_col, a_valid, a_row);
        else passed++;
      end
    end
    drive(1, 1, 16'd40, 0); tick();
    checks++; if (a_data !== 24'sd40) $display("FAIL refrac_resume got=%0d exp=40", a_data); else passed++;
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 1); tick();
    checks++; if (a_spike !== 1'b1) $display("FAIL refrac_refire got=%0b exp=1", a_spike); else passed++;
    checks++; if (a_cnt !== 8'd2) $display("FAIL refrac_cnt got=%0d exp=2", a_cnt); else passed++;
    drive(0, 0, 16'h0000, 0);
  endtask

  task automatic test_threshold_edge();
    apply_reset();
    threshold = 24'sd113;
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 1); tick();
    checks++; if (a_spike !== 1'b1) $display("FAIL thr_equal_fires got=%0b exp=1", a_spike); else passed++;
    apply_reset();
    threshold = 24'sd114;
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 1); tick();
    checks++; if (a_spike !== 1'b0) $display("FAIL thr_above_spike got=%0b exp=0", a_spike); else passed++;
    checks++; if (a_data !== 24'sd113) $display("FAIL thr_above_leak got=%0d exp=113", a_data); else passed++;
    checks++; if (b_data !== 24'sd113) $display("FAIL thr_above_leak_b got=%0d exp=113", b_data); else passed++;
    checks++; if (w_spike !== 1'b1) $display("FAIL thr_noleak_w got=%0b exp=1", w_spike); else passed++;
    drive(0, 0, 16'h0000, 0);
  endtask

  task automatic test_negative_threshold();
    apply_reset();
    threshold = 24'hFFFFFF;
    drive(0, 0, 16'h0000, 1); tick();
    checks++; if (a_spike !== 1'b1) $display("FAIL negthr_spike got=%0b exp=1", a_spike); else passed++;
    checks++; if (b_data !== 24'sd1) $display("FAIL negthr_sub_data got=%0d exp=1", b_data); else passed++;
    checks++; if (w_spike !== 1'b1) $display("FAIL negthr_spike_w got=%0b exp=1", w_spike); else passed++;
    tick();
    checks++; if (a_spike !== 1'b0) $display("FAIL negthr_refrac got=%0b exp=0", a_spike); else passed++;
    checks++; if (w_spike !== 1'b1) $display("FAIL negthr_back_to_back_w got=%0b exp=1", w_spike); else passed++;
    checks++; if (w_cnt !== 8'd2) $display("FAIL negthr_cnt_w got=%0d exp=2", w_cnt); else passed++;
    drive(0, 0, 16'h0000, 0);
  endtask

  task automatic test_saturation();
    apply_reset();
    threshold = 24'sd100;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 16'h7FFF, 0); tick();
    end
    checks++; if (w_data !== 16'sd32767) $display("FAIL sat_pos_w got=%0d exp=32767", w_data); else passed++;
    checks++; if (a_data !== 24'sd131068) $display("FAIL sat_pos_a got=%0d exp=131068", a_data); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 16'h8000, 0); tick();
    end
    checks++; if (w_data !== -16'sd32768) $display("FAIL sat_neg_w got=%0d exp=-32768", w_data); else passed++;
    checks++; if (a_data !== -24'sd4) $display("FAIL sat_neg_a got=%0d exp=-4", a_data); else passed++;
    drive(0, 0, 16'h0000, 0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    threshold = 24'sd100;
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 1); tick();
    drive(0, 0, 16'h0000, 1); tick();
    drive(1, 1, 16'd50, 0); tick();
    checks++; if (a_data !== 24'sd0) $display("FAIL midrst_blocked got=%0d exp=0", a_data); else passed++;
    rst = 1'b1;
    drive(1, 1, 16'd50, 0); tick();
    rst = 1'b0;
    checks++; if (a_data !== 24'sd0 || a_spike !== 1'b0 || a_valid !== 1'b0 || a_row !== 1'b0 || a_col !== 16'h0000)
      $display("FAIL midrst_outputs got=%0d/%0b/%0b/%0b/%h exp=0/0/0/0/0000", a_data, a_spike, a_valid, a_row, a_col);
    else passed++;
    checks++; if (a_cnt !== 8'd0) $display("FAIL midrst_cnt got=%0d exp=0", a_cnt); else passed++;
    drive(1, 1, 16'd40, 0); tick();
    checks++; if (a_data !== 24'sd40) $display("FAIL midrst_integrate got=%0d exp=40", a_data); else passed++;
    drive(1, 1, 16'd40, 0); tick();
    drive(1, 1, 16'd40, 1); tick();
    checks++; if (a_spike !== 1'b1) $display("FAIL midrst_fire got=%0b exp=1", a_spike); else passed++;
    checks++; if (a_cnt !== 8'd1) $display("FAIL midrst_fire_cnt got=%0d exp=1", a_cnt); else passed++;
    drive(0, 0, 16'h0000, 0);
  endtask

  task automatic test_forwarding();
    apply_reset();
    threshold = 24'sd30000;
    drive(1, 1, 16'h1234, 0); tick();
    checks++; if (a_row !== 1'b1 || a_col !== 16'h1234 || a_valid !== 1'b1)
      $display("FAIL fwd_one got=%0b/%h/%0b exp=1/1234/1", a_row, a_col, a_valid);
    else passed++;
    checks++; if (a_data !== 24'sd4660) $display("FAIL fwd_integrate got=%0d exp=4660", a_data); else passed++;
    drive(0, 1, 16'h0100, 0); tick();
    checks++; if (a_row !== 1'b1 || a_col !== 16'h0100 || a_valid !== 1'b0)
      $display("FAIL fwd_invalid got=%0b/%h/%0b exp=1/0100/0", a_row, a_col, a_valid);
    else passed++;
    checks++; if (a_data !== 24'sd4660) $display("FAIL fwd_invalid_nocontrib got=%0d exp=4660", a_data); else passed++;
    drive(0, 0, 16'h0000, 0); tick();
    checks++; if (a_row !== 1'b0 || a_valid !== 1'b0) $display("FAIL fwd_clear got=%0b/%0b exp=0/0", a_row, a_valid); else passed++;
  endtask

  task automatic test_random();
    int     thr;
    int     cv;
    int     errs;
    longint colv;
    errs = 0;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mr[k] = 0; mc[k] = 0; mf[k] = 1'b0;
    end
    thr = 200;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) thr = int'($urandom_range(0, 600)) - 50;
      threshold = 24'(thr);
      if ($urandom_range(0, 9) == 0) in_col = 16'($urandom);
      else begin
        cv = int'($urandom_range(0, 260)) - 60;
        in_col = 16'(cv);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_row   = 1'($urandom_range(0, 1));
      step_end = ($urandom_range(0, 3) == 0);
      colv = longint'($signed(in_col));
      tick();
      for (int k = 0; k < 2; k++) model_tick(k, in_valid, in_row, colv, step_end, longint'(thr));
      checks++;
      if (longint'(a_data) !== mv[0] || a_spike !== mf[0] || int'(a_cnt) !== mc[0] ||
          a_valid !== in_valid || a_row !== in_row || a_col !== in_col) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand_a cyc=%0d got data=%0d spike=%0b cnt=%0d exp data=%0d spike=%0b cnt=%0d",
                   i, a_data, a_spike, a_cnt, mv[0], mf[0], mc[0]);
      end else passed++;
      checks++;
      if (longint'(w_data) !== mv[1] || w_spike !== mf[1] || int'(w_cnt) !== mc[1] ||
          w_valid !== in_valid || w_col !== in_col) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand_w cyc=%0d got data=%0d spike=%0b cnt=%0d exp data=%0d spike=%0b cnt=%0d",
                   i, w_data, w_spike, w_cnt, mv[1], mf[1], mc[1]);
      end else passed++;
    end
    drive(0, 0, 16'h0000, 0);
  endtask

  initial begin
    test_reset();
    test_fire();
    test_refractory();
    test_threshold_edge();
    test_negative_threshold();
    test_saturation();
    test_reset_mid();
    test_forwarding();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
